// File: rtl/bdd_tree_evaluator_if.sv
// Host-side bundle for the BDD tree evaluator: evaluation handshake,
// node-memory load port and classification result.
interface bdd_tree_evaluator_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [23:0]           in_attr;
  logic                  we1;
  logic                  we2;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [33:0]           ram1_data_in;
  logic [17:0]           ram2_data_in;
  logic                  busy;
  logic                  done;
  logic [7:0]            out_class;
  logic                  err;

  modport master (
    output start, in_attr, we1, we2, in_addr, ram1_data_in, ram2_data_in,
    input  busy, done, out_class, err
  );

  modport slave (
    input  start, in_attr, we1, we2, in_addr, ram1_data_in, ram2_data_in,
    output busy, done, out_class, err
  );
endinterface

// File: rtl/bdd_tree_evaluator.sv
// Oblique decision-tree evaluator: per node a 3-term MAC against a threshold
// picks the left or right child until a leaf class (or the visit limit) is hit.
// Node words sit in two synchronous RAMs loaded while idle.
module bdd_tree_evaluator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  bdd_tree_evaluator_if.slave  bus
);

  localparam int VW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_DECIDE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Node memories: {c1,c2,c3,thr} and {left,right}
  logic [33:0] r_mem1 [DEPTH];
  logic [17:0] r_mem2 [DEPTH];
  logic [33:0] r_node_word;
  logic [17:0] r_child_word;

  logic [ADDR_WIDTH-1:0] r_node_addr, w_node_addr_next;
  logic [VW-1:0]         r_visit, w_visit_next;
  logic [17:0]           r_acc, w_acc_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic                  r_err, w_err_next;
  logic [7:0]            r_class, w_class_next;

  logic                  w_load_en;
  logic [7:0]            w_coef;
  logic [7:0]            w_attr;
  logic [15:0]           w_prod;
  logic [17:0]           w_thr_ext;
  logic [8:0]            w_child;
  logic [VW-1:0]         w_visit_inc;

  assign w_load_en   = (r_state == S_IDLE);
  assign w_thr_ext   = {8'd0, r_node_word[9:0]};
  assign w_child     = (r_acc <= w_thr_ext) ? r_child_word[17:9] : r_child_word[8:0];
  assign w_visit_inc = r_visit + 1'b1;
  assign w_prod      = 16'(w_coef) * 16'(w_attr);

  // Load writes only while idle; registered read of the current node every cycle
  always_ff @(posedge clk) begin
    if (w_load_en && bus.we1) begin
      r_mem1[bus.in_addr] <= bus.ram1_data_in;
    end
    if (w_load_en && bus.we2) begin
      r_mem2[bus.in_addr] <= bus.ram2_data_in;
    end
    r_node_word  <= r_mem1[r_node_addr];
    r_child_word <= r_mem2[r_node_addr];
  end

  // Select the coefficient/attribute pair for the current MAC step
  always_comb begin
    w_coef = r_node_word[17:10];
    w_attr = bus.in_attr[7:0];
    case (r_state)
      S_MAC0: begin
        w_coef = r_node_word[33:26];
        w_attr = bus.in_attr[23:16];
      end
      S_MAC1: begin
        w_coef = r_node_word[25:18];
        w_attr = bus.in_attr[15:8];
      end
      default: begin
        w_coef = r_node_word[17:10];
        w_attr = bus.in_attr[7:0];
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_next     = r_state;
    w_node_addr_next = r_node_addr;
    w_visit_next     = r_visit;
    w_acc_next       = r_acc;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_err_next       = r_err;
    w_class_next     = r_class;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_node_addr_next = '0;
          w_visit_next     = '0;
          w_busy_next      = 1'b1;
          w_class_next     = 8'd0;
          w_err_next       = 1'b0;
          w_state_next     = S_FETCH;
        end
      end
      S_FETCH: begin
        w_acc_next   = 18'd0;
        w_state_next = S_MAC0;
      end
      S_MAC0: begin
        w_acc_next   = r_acc + {2'b00, w_prod};
        w_state_next = S_MAC1;
      end
      S_MAC1: begin
        w_acc_next   = r_acc + {2'b00, w_prod};
        w_state_next = S_MAC2;
      end
      S_MAC2: begin
        w_acc_next   = r_acc + {2'b00, w_prod};
        w_state_next = S_DECIDE;
      end
      S_DECIDE: begin
        w_visit_next = w_visit_inc;
        if (w_child[8]) begin
          w_class_next = w_child[7:0];
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = S_IDLE;
        end else if (w_visit_inc == VW'(DEPTH)) begin
          // Visit budget exhausted without reaching a leaf: report a cycle
          w_err_next   = 1'b1;
          w_class_next = 8'd0;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          w_node_addr_next = w_child[ADDR_WIDTH-1:0];
          w_state_next     = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_node_addr <= '0;
      r_visit     <= '0;
      r_acc       <= 18'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_class     <= 8'd0;
    end else begin
      r_node_addr <= w_node_addr_next;
      r_visit     <= w_visit_next;
      r_acc       <= w_acc_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
      r_class     <= w_class_next;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.out_class = r_class;

endmodule

// File: tb/tb_bdd_tree_evaluator.sv
// Self-checking bench for bdd_tree_evaluator: directed vector table,
// multi-cycle corner sequences and random trees against a path-walking model.
module tb_bdd_tree_evaluator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bdd_tree_evaluator_if #(.ADDR_WIDTH(8)) bus ();

  bdd_tree_evaluator #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference copy of the node memories
  logic [33:0] m1 [256];
  logic [17:0] m2 [256];

  typedef struct {
    logic [7:0]  c1, c2, c3;
    logic [9:0]  thr;
    logic [8:0]  left, right;
    logic [23:0] attr;
    logic [7:0]  exp_class;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [33:0] pack1(input logic [7:0] c1, input logic [7:0] c2,
                                         input logic [7:0] c3, input logic [9:0] thr);
    return {c1, c2, c3, thr};
  endfunction

  // Walk the tree: weighted sum per node, compare, follow child
  function automatic void model(input logic [23:0] attr, output logic [7:0] cls,
                                output logic e, output int cyc);
    int node;
    int visits;
    int acc;
    logic [8:0] ch;
    node = 0;
    visits = 0;
    cls = 8'd0;
    e = 1'b0;
    forever begin
      acc = int'(m1[node][33:26]) * int'(attr[23:16])
          + int'(m1[node][25:18]) * int'(attr[15:8])
          + int'(m1[node][17:10]) * int'(attr[7:0]);
      ch = (acc <= int'(m1[node][9:0])) ? m2[node][17:9] : m2[node][8:0];
      visits++;
      if (ch[8]) begin
        cls = ch[7:0];
        break;
      end
      if (visits == 256) begin
        e = 1'b1;
        break;
      end
      node = int'(ch[7:0]);
    end
    cyc = 5 * visits;
  endfunction

  // Called at a negedge; returns at a negedge
  task automatic write_node(input logic [7:0] a, input logic [33:0] d1, input logic [17:0] d2);
    bus.we1 = 1'b1;
    bus.we2 = 1'b1;
    bus.in_addr = a;
    bus.ram1_data_in = d1;
    bus.ram2_data_in = d2;
    @(negedge clk);
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
    m1[a] = d1;
    m2[a] = d2;
  endtask

  // Called at a negedge in IDLE; returns at the negedge where done is seen
  task automatic run_eval(input logic [23:0] attr, input bit do_wr, input logic [7:0] wa,
                          input logic [33:0] d1, input logic [17:0] d2,
                          output int cyc, output logic [7:0] cls, output logic e,
                          output logic busy_ok);
    bus.in_attr = attr;
    bus.start = 1'b1;
    if (do_wr) begin
      bus.we1 = 1'b1;
      bus.we2 = 1'b1;
      bus.in_addr = wa;
      bus.ram1_data_in = d1;
      bus.ram2_data_in = d2;
      m1[wa] = d1;
      m2[wa] = d2;
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    cls = bus.out_class;
    e = bus.err;
  endtask

  initial begin
    int cyc;
    int seen;
    logic [7:0] cls, ecls;
    logic e, eerr, bok;
    int ecyc;
    int cmax;
    logic [23:0] attr;

    vecs[0] = '{8'd1,   8'd2,   8'd3,   10'd20,   9'h105, 9'h107, {8'd2, 8'd3, 8'd4},       8'h05, 1'b0, 5};
    vecs[1] = '{8'd1,   8'd2,   8'd3,   10'd20,   9'h105, 9'h107, {8'd2, 8'd3, 8'd5},       8'h07, 1'b0, 5};
    vecs[2] = '{8'd255, 8'd255, 8'd255, 10'd1023, 9'h100, 9'h1FF, {8'hFF, 8'hFF, 8'hFF},    8'hFF, 1'b0, 5};
    vecs[3] = '{8'd0,   8'd0,   8'd0,   10'd0,    9'h111, 9'h122, {8'hFF, 8'hFF, 8'hFF},    8'h11, 1'b0, 5};
    vecs[4] = '{8'd255, 8'd0,   8'd0,   10'd1020, 9'h1AA, 9'h1BB, {8'd4, 8'd9, 8'd9},       8'hAA, 1'b0, 5};
    vecs[5] = '{8'd128, 8'd0,   8'd0,   10'd1023, 9'h1C2, 9'h1C3, {8'd8, 8'd0, 8'd0},       8'hC3, 1'b0, 5};

    bus.start = 1'b0;
    bus.in_attr = 24'd0;
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
    bus.in_addr = 8'd0;
    bus.ram1_data_in = 34'd0;
    bus.ram2_data_in = 18'd0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    check("reset_class", 32'(bus.out_class), 32'd0);

    // Directed single-node table
    for (int i = 0; i < 6; i++) begin
      write_node(8'd0, pack1(vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].thr),
                 {vecs[i].left, vecs[i].right});
      run_eval(vecs[i].attr, 1'b0, 8'd0, 34'd0, 18'd0, cyc, cls, e, bok);
      $display("vec%0d: class=%0h err=%0d cycles=%0d", i, cls, e, cyc);
      check($sformatf("vec%0d_class", i), 32'(cls), 32'(vecs[i].exp_class));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
      @(negedge clk);
    end

    // Two-level path
    write_node(8'd0, pack1(8'd1, 8'd2, 8'd3, 10'd20), {9'h003, 9'h107});
    write_node(8'd3, pack1(8'd1, 8'd1, 8'd1, 10'd0), {9'h10A, 9'h10B});
    run_eval({8'd2, 8'd3, 8'd4}, 1'b0, 8'd0, 34'd0, 18'd0, cyc, cls, e, bok);
    $display("two_level: class=%0h err=%0d cycles=%0d", cls, e, cyc);
    check("two_level_class", 32'(cls), 32'h0B);
    check("two_level_err", 32'(e), 32'd0);
    check("two_level_cycles", 32'(cyc), 32'd10);
    check("two_level_busy", 32'(bok), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("class_held", 32'(bus.out_class), 32'h0B);

    // Start and write in the same cycle: new node data is used
    run_eval({8'd1, 8'd1, 8'd1}, 1'b1, 8'd0, pack1(8'd1, 8'd1, 8'd1, 10'd5),
             {9'h121, 9'h122}, cyc, cls, e, bok);
    model({8'd1, 8'd1, 8'd1}, ecls, eerr, ecyc);
    $display("start_with_write: class=%0h err=%0d cycles=%0d", cls, e, cyc);
    check("start_wr_class", 32'(cls), 32'(ecls));
    check("start_wr_cycles", 32'(cyc), 32'(ecyc));
    @(negedge clk);

    // Self loop with ignored start/write pulses mid-run
    write_node(8'd0, pack1(8'd1, 8'd2, 8'd3, 10'd20), {9'h000, 9'h000});
    bus.in_attr = {8'd2, 8'd3, 8'd4};
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    bok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 3000) begin
      if (bus.busy !== 1'b1) bok = 1'b0;
      if (cyc == 100) begin
        bus.start = 1'b1;
        bus.we1 = 1'b1;
        bus.we2 = 1'b1;
        bus.in_addr = 8'd0;
        bus.ram1_data_in = pack1(8'd1, 8'd2, 8'd3, 10'd20);
        bus.ram2_data_in = {9'h105, 9'h107};
      end else begin
        bus.start = 1'b0;
        bus.we1 = 1'b0;
        bus.we2 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.we1 = 1'b0;
    bus.we2 = 1'b0;
    $display("self_loop: class=%0h err=%0d cycles=%0d", bus.out_class, bus.err, cyc);
    check("loop_cycles", 32'(cyc), 32'd1280);
    check("loop_err", 32'(bus.err), 32'd1);
    check("loop_class", 32'(bus.out_class), 32'd0);
    check("loop_busy", 32'(bok), 32'd1);
    repeat (3) @(negedge clk);
    check("loop_err_held", 32'(bus.err), 32'd1);
    check("loop_done_low", 32'(bus.done), 32'd0);
    // Memory must still hold the self loop
    run_eval({8'd2, 8'd3, 8'd4}, 1'b0, 8'd0, 34'd0, 18'd0, cyc, cls, e, bok);
    $display("self_loop_rerun: class=%0h err=%0d cycles=%0d", cls, e, cyc);
    check("rerun_cycles", 32'(cyc), 32'd1280);
    check("rerun_err", 32'(e), 32'd1);
    @(negedge clk);

    // Reset asserted during MAC1
    write_node(8'd0, pack1(8'd1, 8'd2, 8'd3, 10'd20), {9'h105, 9'h107});
    bus.in_attr = {8'd2, 8'd3, 8'd4};
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;   // FETCH
    @(negedge clk);     // MAC0
    @(negedge clk);     // MAC1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("mid_reset: busy=%0d done=%0d class=%0h err=%0d", bus.busy, bus.done, bus.out_class, bus.err);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_class", 32'(bus.out_class), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);
    run_eval({8'd2, 8'd3, 8'd4}, 1'b0, 8'd0, 34'd0, 18'd0, cyc, cls, e, bok);
    $display("after_reset: class=%0h err=%0d cycles=%0d", cls, e, cyc);
    check("after_rst_class", 32'(cls), 32'h05);
    check("after_rst_cycles", 32'(cyc), 32'd5);
    // Back-to-back: start presented while done is high
    run_eval({8'd2, 8'd3, 8'd5}, 1'b0, 8'd0, 34'd0, 18'd0, cyc, cls, e, bok);
    $display("back_to_back: class=%0h err=%0d cycles=%0d", cls, e, cyc);
    check("b2b_class", 32'(cls), 32'h07);
    check("b2b_cycles", 32'(cyc), 32'd5);
    @(negedge clk);

    // Random trees on nodes 0..15 against the model
    for (int t = 0; t < 10; t++) begin
      cmax = ($urandom_range(0, 1) != 0) ? 255 : 3;
      for (int n = 0; n < 16; n++) begin
        logic [8:0] l, r;
        l = ($urandom_range(0, 1) != 0) ? {1'b1, 8'($urandom)} : {1'b0, 8'($urandom_range(0, 15))};
        r = ($urandom_range(0, 1) != 0) ? {1'b1, 8'($urandom)} : {1'b0, 8'($urandom_range(0, 15))};
        write_node(8'(n), pack1(8'($urandom_range(0, cmax)), 8'($urandom_range(0, cmax)),
                               8'($urandom_range(0, cmax)), 10'($urandom)), {l, r});
      end
      for (int k = 0; k < 3; k++) begin
        attr = 24'($urandom);
        model(attr, ecls, eerr, ecyc);
        run_eval(attr, 1'b0, 8'd0, 34'd0, 18'd0, cyc, cls, e, bok);
        $display("rand t%0d k%0d: attr=%06h class=%0h err=%0d cycles=%0d (model %0h %0d %0d)",
                 t, k, attr, cls, e, cyc, ecls, eerr, ecyc);
        check($sformatf("rand%0d_%0d_class", t, k), 32'(cls), 32'(ecls));
        check($sformatf("rand%0d_%0d_err", t, k), 32'(e), 32'(eerr));
        check($sformatf("rand%0d_%0d_cycles", t, k), 32'(cyc), 32'(ecyc));
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bdd_tree_evaluator.md
# bdd_tree_evaluator

Hardware evaluator for an oblique binary decision tree (BDD) classifier. Node coefficients and child pointers live in two on-chip synchronous SRAMs. A multiply-accumulate unit forms a weighted sum of three 8-bit attributes per node, and a comparator selects the next node until a leaf class is reached. It is a single-clock datapath core wrapping the SRAM, MAC and clock-enable sequencing of the accelerator.

## Interface
- ADDR_WIDTH, 8: node address width.
- DEPTH, 256: node count per SRAM; equals 2^ADDR_WIDTH.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin evaluation at node 0; sampled only in IDLE.
- in_attr  in  24  attributes {x0[23:16], x1[15:8], x2[7:0]}, unsigned; must stay stable while busy.
- we1  in  1  write enable, RAM1 (coefficients).
- we2  in  1  write enable, RAM2 (children).
- in_addr  in  ADDR_WIDTH  load address for both RAMs.
- ram1_data_in  in  34  node word {c1[33:26], c2[25:18], c3[17:10], thr[9:0]}.
- ram2_data_in  in  18  child word {left[17:9], right[8:0]}; child = {leaf[8], value[7:0]}.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of evaluation.
- out_class  out  8  class of reached leaf; held until next start.
- err  out  1  visit limit hit; valid with done, held until next start.

## Operation
- Loading: in IDLE, we1/we2 write the ram data at in_addr on the clock edge. Writes while busy are ignored. Contents are unaffected by rst and uninitialised after power-up.
- States: IDLE, FETCH, MAC0, MAC1, MAC2, DECIDE.
- IDLE, start=1: node address <= 0, visit count <= 0, busy <= 1, out_class <= 0, err <= 0, go to FETCH.
- FETCH: node address is presented to both SRAMs; registered read data is valid in MAC0. acc <= 0.
- MAC0/1/2: acc <= acc + c1*x0, then c2*x1, then c3*x2.
  - Products are 8x8 unsigned, 16-bit.
  - acc is 18 bits unsigned (max 195075, no overflow).
- DECIDE: if acc <= zero-extended thr, choose left, else choose right. Increment visit count.
  - Chosen leaf=1: out_class <= value; go to IDLE with done=1.
  - Chosen leaf=0: node address <= value[ADDR_WIDTH-1:0]; go to FETCH.
  - Visit count reaching DEPTH on a non-leaf: err <= 1, out_class <= 0, done, go to IDLE.
- start while busy is ignored.
- start and we1/we2 together in IDLE: the write is performed and evaluation starts. Node reads observe the new data.

## Timing
- Each node costs exactly 5 cycles (FETCH, MAC0, MAC1, MAC2, DECIDE).
- start sampled at edge k, path of N nodes: done is high during the cycle after edge k+5N, for exactly one cycle. busy is high after edges k..k+5N-1. out_class/err are valid with done.
- SRAM read latency: 1 cycle (address registered at edge, data valid next cycle).
- Write latency: the written data is readable from the next edge.
- rst mid-operation: state goes to IDLE at the next edge. busy, done, err and out_class are forced to 0 and acc is cleared. Memories are retained.
- Reset values: busy=0, done=0, err=0, out_class=0.
- done and a new start may be sampled back-to-back. The next start is accepted the cycle done is high, since the state is IDLE.

## Test plan
- Node0 = {c1=1,c2=2,c3=3,thr=20}, RAM2[0] = {left=9'h105, right=9'h107}, in_attr=(2,3,4) -> acc=20 (equal case) -> out_class=5, done 5 cycles after start, err=0.
- Same memory, in_attr=(2,3,5) -> acc=23 > 20 -> out_class=7, done after 5 cycles.
- Two-level path: RAM2[0].left=9'h003, node3 = {1,1,1,thr=0} with RAM2[3] = {9'h10A, 9'h10B}, in_attr=(2,3,4) -> out_class=0x0B, done after 10 cycles, busy high throughout.
- Extreme values: all coefficients 255, in_attr=(255,255,255), thr=1023 -> acc=195075 -> right child; leaf 9'h1FF -> out_class=0xFF.
- Self loop: RAM2[0] = {9'h000, 9'h000} -> done after 1280 cycles, err=1, out_class=0. A second start and writes pulsed mid-run are ignored, and memory is unchanged afterwards.
- Reset mid-run, asserted at MAC1 -> next cycle busy=0, done=0, out_class=0. A fresh start then reproduces the first scenario exactly.
